// File: rtl/buffer_dma_router.sv
// buffer_dma_router: accepts DMA write bursts, decodes the target buffer region
// and streams beats into it, draining unmapped or region-crossing bursts with an error response.
module buffer_dma_router #(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH = 8,
    parameter int LOCAL_AW = 15,
    parameter logic [ADDR_WIDTH-1:0] REGION_BASE [NUM_REGIONS] = '{32'h0, 32'h8000, 32'hC000, 32'h10000},
    parameter int REGION_SIZE_LOG2 [NUM_REGIONS] = '{15, 14, 14, 13}
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]   cmd_len_i,
    input  logic                   dat_valid_i,
    output logic                   dat_ready_o,
    input  logic [DATA_WIDTH-1:0]  dat_data_i,
    output logic [NUM_REGIONS-1:0] buf_wr_en_o,
    output logic [LOCAL_AW-1:0]    buf_wr_addr_o,
    output logic [DATA_WIDTH-1:0]  buf_wr_data_o,
    input  logic [NUM_REGIONS-1:0] buf_wr_ready_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic                   rsp_err_o,
    output logic                   busy_o,
    output logic [31:0]            beats_written_o,
    output logic [15:0]            err_count_o
);
    localparam int SW = NUM_REGIONS > 1 ? $clog2(NUM_REGIONS) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, RESP} state_t;

    state_t state, state_nx;
    logic [SW-1:0] sel, d_sel;
    logic [LOCAL_AW-1:0] laddr, d_local;
    logic [LEN_WIDTH-1:0] cnt;
    logic err, d_legal, accept, commit, take;
    logic [ADDR_WIDTH:0] last_addr, region_end;

    assign accept = cmd_valid_i && cmd_ready_o;
    assign commit = state == STREAM && dat_valid_i && buf_wr_ready_i[sel];
    assign take = state == DRAIN && dat_valid_i;
    assign last_addr = {1'b0, cmd_addr_i} + (ADDR_WIDTH+1)'(cmd_len_i);
    assign buf_wr_addr_o = laddr;
    assign buf_wr_data_o = dat_data_i;

    // Scan from the top index down so the lowest hitting region wins on overlap.
    always_comb begin
        d_sel = '0;
        d_local = '0;
        d_legal = 1'b0;
        region_end = '0;
        for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
            region_end = {1'b0, REGION_BASE[r]} + ((ADDR_WIDTH+1)'(1) << REGION_SIZE_LOG2[r]);
            if (cmd_addr_i >= REGION_BASE[r] && {1'b0, cmd_addr_i} < region_end) begin
                d_sel = SW'(r);
                d_local = LOCAL_AW'(cmd_addr_i - REGION_BASE[r]);
                d_legal = last_addr < region_end;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cmd_valid_i) state_nx = d_legal ? STREAM : DRAIN;
            STREAM:  if (commit && cnt == '0) state_nx = RESP;
            DRAIN:   if (take && cnt == '0) state_nx = RESP;
            RESP:    if (rsp_ready_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o = state == IDLE && !rst_i;
        dat_ready_o = state == STREAM ? buf_wr_ready_i[sel] : state == DRAIN;
        buf_wr_en_o = (state == STREAM && dat_valid_i) ? NUM_REGIONS'(1) << sel : '0;
        rsp_valid_o = state == RESP;
        rsp_err_o = state == RESP && err;
        busy_o = state != IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel <= '0;
            laddr <= '0;
            cnt <= '0;
            err <= 1'b0;
            beats_written_o <= '0;
            err_count_o <= '0;
        end else begin
            if (accept) begin
                sel <= d_sel;
                laddr <= d_local;
                cnt <= cmd_len_i;
                err <= !d_legal;
                if (!d_legal && err_count_o != '1) err_count_o <= err_count_o + 16'd1;
            end
            if (commit) begin
                laddr <= laddr + LOCAL_AW'(1);
                cnt <= cnt - LEN_WIDTH'(1);
                if (beats_written_o != '1) beats_written_o <= beats_written_o + 32'd1;
            end
            if (take) cnt <= cnt - LEN_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_buffer_dma_router.sv
// tb_buffer_dma_router: directed and randomized bursts against a transaction-level model
// of region decode, beat routing, responses and counters.
module tb_buffer_dma_router;
    logic clk = 0, rst = 1;
    logic cmd_valid = 0, cmd_ready;
    logic [31:0] cmd_addr = 0;
    logic [7:0] cmd_len = 0;
    logic dat_valid = 0, dat_ready;
    logic [31:0] dat_data = 0;
    logic [3:0] wr_en, wr_ready = 4'hF;
    logic [14:0] wr_addr;
    logic [31:0] wr_data;
    logic rsp_valid, rsp_ready = 1, rsp_err, busy;
    logic [31:0] beats;
    logic [15:0] errs;

    int checks = 0, errors = 0;
    bit chk_en = 0, rnd = 0;
    logic [3:0] fix_wr = 4'hF;
    logic fix_rsp = 1;
    longint base_tab[4] = '{64'h0, 64'h8000, 64'hC000, 64'h10000};
    int size_log2[4] = '{15, 14, 14, 13};

    bit m_burst = 0, m_resp = 0, m_legal = 0, m_err = 0;
    int m_reg = 0, m_rem = 0, m_pos = 0, m_loc = 0, m_errs = 0;
    longint m_beats = 0;
    logic [3:0] log_en[$];
    int log_addr[$];

    always #5 clk = ~clk;

    buffer_dma_router dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .dat_valid_i(dat_valid), .dat_ready_o(dat_ready), .dat_data_i(dat_data),
        .buf_wr_en_o(wr_en), .buf_wr_addr_o(wr_addr), .buf_wr_data_o(wr_data), .buf_wr_ready_i(wr_ready),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_err_o(rsp_err), .busy_o(busy),
        .beats_written_o(beats), .err_count_o(errs)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int region_of(input longint a);
        for (int r = 0; r < 4; r++)
            if (a >= base_tab[r] && a < base_tab[r] + (longint'(1) << size_log2[r])) return r;
        return -1;
    endfunction

    function automatic bit is_legal(input longint a, input longint l);
        return region_of(a) >= 0 && region_of(a + l) == region_of(a);
    endfunction

    // Per-cycle comparison against the model, then advance the model across the coming edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", cmd_ready, !rst && !m_burst && !m_resp);
            chk("busy", busy, m_burst || m_resp);
            chk("dat_ready", dat_ready, m_burst ? (m_legal ? wr_ready[m_reg] : 1'b1) : 1'b0);
            chk("wr_en", wr_en, (m_burst && m_legal && dat_valid) ? 4'(1 << m_reg) : 4'h0);
            if (m_burst && m_legal) chk("wr_addr", wr_addr, m_loc + m_pos);
            if (wr_en != 0) chk("wr_data", wr_data, dat_data);
            chk("rsp_valid", rsp_valid, m_resp);
            chk("rsp_err", rsp_err, m_resp && m_err);
            chk("beats_written", beats, m_beats);
            chk("err_count", errs, m_errs);
            if ((wr_en & wr_ready) != 0) begin
                log_en.push_back(wr_en);
                log_addr.push_back(int'(wr_addr));
            end
        end
        if (rst) begin
            m_burst = 0; m_resp = 0; m_beats = 0; m_errs = 0;
        end else if (m_resp) begin
            if (rsp_ready) m_resp = 0;
        end else if (m_burst) begin
            if (dat_valid && (m_legal ? wr_ready[m_reg] : 1'b1)) begin
                if (m_legal) begin
                    m_pos++;
                    if (m_beats < 64'hFFFF_FFFF) m_beats++;
                end
                m_rem--;
                if (m_rem == 0) begin m_burst = 0; m_resp = 1; end
            end
        end else if (cmd_valid) begin
            m_reg = region_of(cmd_addr);
            m_legal = is_legal(cmd_addr, cmd_len);
            m_err = !m_legal;
            m_loc = m_legal ? int'(cmd_addr - base_tab[m_reg]) : 0;
            m_pos = 0;
            m_rem = cmd_len + 1;
            m_burst = 1;
            if (!m_legal && m_errs < 'hFFFF) m_errs++;
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        wr_ready = rnd ? (4'($urandom) | 4'($urandom)) : fix_wr;
        rsp_ready = rnd ? 1'($urandom) : fix_rsp;
    end

    task automatic send_cmd(input logic [31:0] a, input logic [7:0] l);
        int n = 0;
        bit ok = 0;
        cmd_valid = 1; cmd_addr = a; cmd_len = l;
        do begin
            @(negedge clk); ok = cmd_ready;
            @(posedge clk); #1; n++;
        end while (!ok && n < 100);
        cmd_valid = 0;
        chk("cmd_accept", ok, 1);
    endtask

    task automatic send_beats(input int n, input bit rv);
        int got = 0, t = 0;
        bit acc;
        while (got < n && t < 1000) begin
            dat_valid = rv ? ($urandom % 4 != 0) : 1'b1;
            dat_data = $urandom;
            @(negedge clk); acc = dat_valid && dat_ready;
            @(posedge clk); #1;
            if (acc) got++;
            t++;
        end
        dat_valid = 0;
        chk("beats_taken", got, n);
    endtask

    task automatic wait_rsp(output logic e);
        int t = 0;
        bit ok = 0;
        e = 0;
        while (!ok && t < 500) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin ok = 1; e = rsp_err; end
            @(posedge clk); #1; t++;
        end
        chk("rsp_seen", ok, 1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic e;
        int l0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1;
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_beats", beats, 0);
        chk("rst_errs", errs, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        rst = 0;
        #1 chk("post_rst_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;

        l0 = log_addr.size();
        send_cmd(32'h8010, 3); send_beats(4, 0); wait_rsp(e);
        chk("r1_err", e, 0);
        chk("r1_beats", beats, 4);
        chk("r1_nwrites", log_addr.size() - l0, 4);
        for (int i = 0; i < 4 && l0 + i < log_addr.size(); i++) begin
            chk("r1_en", log_en[l0+i], 4'b0010);
            chk("r1_addr", log_addr[l0+i], 'h10 + i);
        end

        l0 = log_addr.size();
        send_cmd(32'hBFFE, 3); send_beats(4, 0); wait_rsp(e);
        chk("cross_err", e, 1);
        chk("cross_errs", errs, 1);
        chk("cross_nwrites", log_addr.size() - l0, 0);

        send_cmd(32'h20000, 0); send_beats(1, 0); wait_rsp(e);
        chk("unmapped_err", e, 1);
        chk("unmapped_errs", errs, 2);

        l0 = log_addr.size();
        send_cmd(32'h10000, 7); send_beats(2, 0);
        fix_wr = 4'b0111;
        for (int i = 0; i < 5; i++) begin
            dat_valid = 1; dat_data = $urandom;
            @(negedge clk);
            chk("stall_dat_ready", dat_ready, 0);
            chk("stall_addr", wr_addr, 2);
            @(posedge clk); #1;
        end
        fix_wr = 4'hF;
        send_beats(6, 0); wait_rsp(e);
        chk("stall_err", e, 0);
        chk("stall_nwrites", log_addr.size() - l0, 8);
        for (int i = 0; i < 8 && l0 + i < log_addr.size(); i++) begin
            chk("stall_en", log_en[l0+i], 4'b1000);
            chk("stall_waddr", log_addr[l0+i], i);
        end
        chk("stall_beats", beats, 12);

        fix_rsp = 0;
        send_cmd(32'h8000, 1); send_beats(2, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_err", rsp_err, 0);
            chk("hold_cmd_ready", cmd_ready, 0);
            @(posedge clk); #1;
        end
        fix_rsp = 1;
        wait_rsp(e);
        chk("hold_err", e, 0);
        chk("hold_beats", beats, 14);

        send_cmd(32'h100, 7); send_beats(2, 0);
        rst = 1; dat_valid = 1;
        @(posedge clk); #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_dat_ready", dat_ready, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_beats", beats, 0);
        chk("mid_rst_errs", errs, 0);
        chk("mid_rst_wr_addr", wr_addr, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        rst = 0; dat_valid = 0;
        #1 chk("rel_cmd_ready", cmd_ready, 1);
        repeat (3) @(posedge clk);
        #1;

        rnd = 1;
        for (int n = 0; n < 60; n++) begin
            int r;
            longint a, sz;
            logic [7:0] l;
            r = $urandom % 5;
            l = ($urandom % 8 == 0) ? 8'($urandom % 64) : 8'($urandom % 16);
            if (r == 4) a = 64'h12000 + $urandom % 'h10000;
            else begin
                sz = longint'(1) << size_log2[r];
                a = base_tab[r] + (($urandom % 2) ? sz - 1 - $urandom % 20 : $urandom % sz);
            end
            send_cmd(32'(a), l); send_beats(l + 1, 1); wait_rsp(e);
            chk("rand_err", e, !is_legal(a, l));
        end
        rnd = 0;
        repeat (2) @(posedge clk);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/buffer_dma_router.md
BUFFER_DMA_ROUTER -- requirements
Module: buffer_dma_router

Interface
REQ-001 Parameter NUM_REGIONS, default 4: number of destination buffer regions.
REQ-002 Parameter ADDR_WIDTH, default 32: DMA word-address width.
REQ-003 Parameter DATA_WIDTH, default 32: beat data width.
REQ-004 Parameter LEN_WIDTH, default 8: burst length field width; bursts of 1..2^LEN_WIDTH beats.
REQ-005 Parameter LOCAL_AW, default 15: region-local address width, equal to or greater than every REGION_SIZE_LOG2 entry.
REQ-006 Parameter REGION_BASE[NUM_REGIONS], default {0x0,0x8000,0xC000,0x10000}: word-address base per region.
REQ-007 Parameter REGION_SIZE_LOG2[NUM_REGIONS], default {15,14,14,13}: log2 region size in words.
REQ-008 Port clk_i, input, 1: sole clock, rising edge.
REQ-009 Port rst_i, input, 1: reset, synchronous, active-high.
REQ-010 Port cmd_valid_i/cmd_ready_o, in/out, 1/1: burst command handshake.
REQ-011 Port cmd_addr_i, input, ADDR_WIDTH: first beat word address.
REQ-012 Port cmd_len_i, input, LEN_WIDTH: beats minus one.
REQ-013 Port dat_valid_i/dat_ready_o, in/out, 1/1: write-data beat handshake.
REQ-014 Port dat_data_i, input, DATA_WIDTH: beat data.
REQ-015 Port buf_wr_en_o, output, NUM_REGIONS: one-hot region write strobe.
REQ-016 Port buf_wr_addr_o, output, LOCAL_AW: region-local word address.
REQ-017 Port buf_wr_data_o, output, DATA_WIDTH: write data.
REQ-018 Port buf_wr_ready_i, input, NUM_REGIONS: per-region write acceptance.
REQ-019 Port rsp_valid_o/rsp_ready_i, out/in, 1/1: burst completion handshake.
REQ-020 Port rsp_err_o, output, 1: burst was unmapped or region-crossing, so it was discarded.
REQ-021 Port busy_o, output, 1: FSM not in IDLE.
REQ-022 Port beats_written_o, output, 32: saturating count of beats committed to regions.
REQ-023 Port err_count_o, output, 16: saturating count of error bursts.

Function
REQ-024 FSM states SHALL be IDLE, STREAM, DRAIN, RESP.
REQ-025 cmd_ready_o SHALL be 1 only in IDLE; a command is accepted on cmd_valid_i&cmd_ready_o.
REQ-026 Decode on accept: region r hits if REGION_BASE[r] <= addr < REGION_BASE[r]+2^REGION_SIZE_LOG2[r]; on overlap, the lowest hitting index wins.
REQ-027 A burst is legal iff the region hits and addr+len stays in the same region; legal goes to STREAM, illegal goes to DRAIN. Compute the sum with one extra bit so it cannot overflow.
REQ-028 On accept, the FSM SHALL latch the region index, local address = addr-REGION_BASE[r] and the beat counter = len.
REQ-029 STREAM: dat_ready_o = buf_wr_ready_i[sel]; buf_wr_en_o[sel] = dat_valid_i; all other strobes 0; data and address pass through combinationally.
REQ-030 A beat commits on dat_valid_i&buf_wr_ready_i[sel]; the local address increments by 1 and the beat counter decrements.
REQ-031 DRAIN: dat_ready_o=1, all strobes 0, and beats are consumed and discarded until len+1 beats are taken.
REQ-032 After the final beat of STREAM or DRAIN, the FSM SHALL enter RESP on the next cycle; first-beat acceptance is possible the cycle after command accept.
REQ-033 RESP: rsp_valid_o=1, rsp_err_o=1 iff the burst came from DRAIN; both are held stable until rsp_ready_i, then the FSM returns to IDLE.
REQ-034 In IDLE and RESP, dat_ready_o=0 and buf_wr_en_o=0.
REQ-035 beats_written_o SHALL increment per committed STREAM beat and saturate at 0xFFFFFFFF.
REQ-036 err_count_o SHALL increment once per illegal command at accept and saturate at 0xFFFF.
REQ-037 buf_wr_ready_i=0 mid-burst SHALL stall without losing the address or count; a beat with dat_valid_i=0 causes no write.

Reset
REQ-038 rst_i high at a clock edge SHALL force IDLE, cmd_ready_o=0 during reset, and set dat_ready_o, buf_wr_en_o, rsp_valid_o, rsp_err_o, busy_o, buf_wr_addr_o, beats_written_o and err_count_o to 0.
REQ-039 Reset mid-burst SHALL abandon the burst with no response; remaining beats are not consumed.

Verification
REQ-040 Command addr=0x8010, len=3, then 4 beats with region1 ready -> buf_wr_en_o=0b0010 at addrs 0x10..0x13, rsp_valid_o with err=0, beats_written_o=4.
REQ-041 Command addr=0xBFFE, len=3 (crosses region 1 end) -> 4 beats consumed with no strobe, rsp_err_o=1, err_count_o=1.
REQ-042 Command addr=0x20000 (unmapped), len=0 -> 1 beat drained, rsp_err_o=1.
REQ-043 buf_wr_ready_i[3]=0 for 5 cycles during a burst at 0x10000 -> dat_ready_o=0 and the address is frozen; resume writes 0x0000.. in order.
REQ-044 rst_i asserted after 2 of 8 beats -> all outputs 0 next cycle, cmd_ready_o=1 the cycle after release, no rsp_valid_o.
REQ-045 rsp_ready_i=0 for 3 cycles -> rsp_valid_o and rsp_err_o held, cmd_ready_o=0 until the response is accepted.
